speed_ramp_ctrl: RTL and testbench



---
 rtl/speed_ramp_pkg.sv | 14 +
 rtl/speed_ramp_ctrl_dwell.sv | 34 +++
 rtl/speed_ramp_ctrl.sv | 176 +++++++++++++++++
 tb/tb_speed_ramp_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/speed_ramp_pkg.sv
// Shared state encoding and default widths for the speed ramp sequencer.
package speed_ramp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_HOLD = 2'd3
  } ramp_state_e;

  localparam int SPEED_W_DFLT = 11;
  localparam int DWELL_W_DFLT = 8;

endpackage

// File: rtl/speed_ramp_ctrl_dwell.sv
// dwell_counter: counts wrap pulses and flags the wrap that reaches the target.
module dwell_counter
  import speed_ramp_pkg::*;
#(
  parameter int CNT_W = DWELL_W_DFLT + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wrap,
  input  logic [CNT_W-1:0] target,
  output logic             tick
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign tick      = wrap & (w_cnt_inc >= target);

  // Wrap counter; restarts after every completing wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || tick) begin
      r_cnt <= '0;
    end else if (wrap) begin
      r_cnt <= w_cnt_inc;
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/speed_ramp_ctrl.sv
// Triangle sweep sequencer for the LED counter speed input.
// Optional peak dwell at max is enabled with `define SPEED_RAMP_PEAK_HOLD_EN.
module speed_ramp_ctrl
  import speed_ramp_pkg::*;
#(
  parameter int LOOPS   = 4,
  parameter int SPEED_W = SPEED_W_DFLT,
  parameter int DWELL_W = DWELL_W_DFLT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               wrap,
  input  logic [SPEED_W-1:0] min_speed,
  input  logic [SPEED_W-1:0] max_speed,
  input  logic [SPEED_W-1:0] step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SPEED_W-1:0] speed,
  output logic               busy,
  output logic               dir,
  output logic               done
);

  localparam logic [15:0]        LOOP_TGT  = 16'(LOOPS);
  localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  ramp_state_e        r_state, w_state;
  logic [SPEED_W-1:0] r_speed, w_speed;
  logic [SPEED_W-1:0] r_min, w_min;
  logic [SPEED_W-1:0] r_max, w_max;
  logic [SPEED_W-1:0] r_step, w_step;
  logic [DWELL_W-1:0] r_dwell, w_dwell;
  logic [15:0]        r_loops, w_loops;
  logic               r_done, w_done;

  logic               w_tick;
  logic               w_clr;
  logic               w_wrap;
  logic [DWELL_W:0]   w_target;
  logic [SPEED_W:0]   w_sum;
  logic [SPEED_W:0]   w_floor;
  logic [SPEED_W-1:0] w_down_speed;
  logic [15:0]        w_loops_inc;

  assign w_wrap      = wrap & (r_state != ST_IDLE);
  assign w_clr       = stop | (r_state == ST_IDLE);
  // HOLD lasts twice the programmed dwell.
  assign w_target    = (r_state == ST_HOLD) ? {r_dwell, 1'b0} : {1'b0, r_dwell};
  assign w_sum       = {1'b0, r_speed} + {1'b0, r_step};
  assign w_floor     = {1'b0, r_min} + {1'b0, r_step};
  assign w_down_speed = ({1'b0, r_speed} < w_floor) ? r_min : (r_speed - r_step);
  assign w_loops_inc = r_loops + 16'd1;

  dwell_counter #(.CNT_W(DWELL_W + 1)) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (w_clr),
    .wrap   (w_wrap),
    .target (w_target),
    .tick   (w_tick)
  );

  // Next-state and datapath decode; stop beats every other event.
  always_comb begin
    w_state = r_state;
    w_speed = r_speed;
    w_min   = r_min;
    w_max   = r_max;
    w_step  = r_step;
    w_dwell = r_dwell;
    w_loops = r_loops;
    w_done  = 1'b0;
    if ((r_state != ST_IDLE) && stop) begin
      w_state = ST_IDLE;
      w_speed = r_min;
      w_loops = 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_min   = min_speed;
            w_max   = max_speed;
            w_step  = step;
            w_dwell = (dwell == '0) ? DWELL_ONE : dwell;
            if ((min_speed >= max_speed) || (step == '0)) begin
              w_done = 1'b1;
            end else begin
              w_speed = min_speed;
              w_state = ST_UP;
              w_loops = 16'd0;
            end
          end else begin
            w_state = ST_IDLE;
          end
        end
        ST_UP: begin
          if (w_tick) begin
            if (w_sum >= {1'b0, r_max}) begin
              w_speed = r_max;
`ifdef SPEED_RAMP_PEAK_HOLD_EN
              w_state = ST_HOLD;
`else
              w_state = ST_DOWN;
`endif
            end else begin
              w_speed = w_sum[SPEED_W-1:0];
            end
          end else begin
            w_state = ST_UP;
          end
        end
`ifdef SPEED_RAMP_PEAK_HOLD_EN
        ST_HOLD: begin
          if (w_tick) begin
            w_state = ST_DOWN;
          end else begin
            w_state = ST_HOLD;
          end
        end
`endif
        ST_DOWN: begin
          if (w_tick) begin
            w_speed = w_down_speed;
            if (w_down_speed == r_min) begin
              if ((LOOP_TGT != 16'd0) && (w_loops_inc == LOOP_TGT)) begin
                w_done  = 1'b1;
                w_state = ST_IDLE;
                w_loops = 16'd0;
              end else begin
                w_loops = w_loops_inc;
                w_state = ST_UP;
              end
            end else begin
              w_state = ST_DOWN;
            end
          end else begin
            w_state = ST_DOWN;
          end
        end
        default: begin
          w_state = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_speed <= '0;
      r_min   <= '0;
      r_max   <= '0;
      r_step  <= '0;
      r_dwell <= '0;
      r_loops <= 16'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_speed <= w_speed;
      r_min   <= w_min;
      r_max   <= w_max;
      r_step  <= w_step;
      r_dwell <= w_dwell;
      r_loops <= w_loops;
      r_done  <= w_done;
    end
  end

  assign speed = r_speed;
  assign busy  = (r_state != ST_IDLE);
  assign dir   = (r_state == ST_UP);
  assign done  = r_done;

endmodule

// File: tb/tb_speed_ramp_ctrl.sv
// Scoreboard bench for speed_ramp_ctrl (LOOPS=1); follows SPEED_RAMP_PEAK_HOLD_EN when defined.
module tb_speed_ramp_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        wrap = 1'b0;
  logic [10:0] min_speed = 11'd0;
  logic [10:0] max_speed = 11'd0;
  logic [10:0] step = 11'd0;
  logic [7:0]  dwell = 8'd0;
  logic [10:0] speed;
  logic        busy;
  logic        dir;
  logic        done;

  typedef struct {
    int v;
    int c;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  logic [10:0] last_speed = 11'd0;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  speed_ramp_ctrl #(.LOOPS(1), .SPEED_W(11), .DWELL_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .wrap      (wrap),
    .min_speed (min_speed),
    .max_speed (max_speed),
    .step      (step),
    .dwell     (dwell),
    .speed     (speed),
    .busy      (busy),
    .dir       (dir),
    .done      (done)
  );

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Every speed change must match the next scoreboard entry, value and cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done) done_cnt++;
      if (speed != last_speed) begin
        if (sb_q.size() == 0) begin
          check_val("sb_unexpected", speed, last_speed);
        end else begin
          mon_e = sb_q.pop_front();
          check_val("sb_speed", speed, mon_e.v);
          check_val("sb_cycle", cyc, mon_e.c);
        end
        last_speed = speed;
      end
    end
  end

  task automatic push_exp(input int v);
    exp_t e;
    e.v = v;
    e.c = cyc + 1;
    sb_q.push_back(e);
  endtask

  task automatic start_ramp(input int mn, input int mx, input int st, input int dw, input bit chg);
    min_speed = 11'(mn);
    max_speed = 11'(mx);
    step      = 11'(st);
    dwell     = 8'(dw);
    if (chg) push_exp(mn);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse(input bit w, input bit s, input bit chg, input int v);
    if (chg) push_exp(v);
    wrap = w;
    stop = s;
    @(posedge clk);
    #1;
    wrap = 1'b0;
    stop = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input bit chg, input int v);
    pulse(1'b1, 1'b0, chg, v);
    idle(19);
  endtask

  task automatic hold_wraps(input int n);
`ifdef SPEED_RAMP_PEAK_HOLD_EN
    for (int i = 0; i < n; i++) wr(1'b0, 0);
`else
    if (n < 0) wr(1'b0, 0);
`endif
  endtask

  initial begin
    idle(3);
    check_val("rst_speed", speed, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_dir", dir, 0);
    check_val("rst_done", done, 0);
    rst_n = 1'b1;
    last_speed = 11'd0;
    mon_en = 1'b1;
    idle(2);

    // Basic triangle 2,6,10,6,2
    start_ramp(2, 10, 4, 1, 1'b1);
    check_val("t1_busy", busy, 1);
    check_val("t1_dir", dir, 1);
    wr(1'b1, 6);
    wr(1'b1, 10);
    check_val("t1_dir_peak", dir, 0);
    hold_wraps(2);
    wr(1'b1, 6);
    pulse(1'b1, 1'b0, 1'b1, 2);
    check_val("t1_done", done, 1);
    check_val("t1_busy_end", busy, 0);
    idle(1);
    check_val("t1_done_clr", done, 0);
    idle(18);

    // Clamping at both bounds: 2,6,9,5,2
    start_ramp(2, 9, 4, 1, 1'b0);
    check_val("t2_busy", busy, 1);
    wr(1'b1, 6);
    wr(1'b1, 9);
    hold_wraps(2);
    wr(1'b1, 5);
    pulse(1'b1, 1'b0, 1'b1, 2);
    check_val("t2_done", done, 1);
    idle(19);

    // dwell=3: change only on every third wrap
    start_ramp(3, 11, 4, 3, 1'b1);
    wr(1'b0, 0); wr(1'b0, 0); wr(1'b1, 7);
    wr(1'b0, 0); wr(1'b0, 0); wr(1'b1, 11);
    hold_wraps(6);
    wr(1'b0, 0); wr(1'b0, 0); wr(1'b1, 7);
    wr(1'b0, 0); wr(1'b0, 0);
    pulse(1'b1, 1'b0, 1'b1, 3);
    check_val("t3_done", done, 1);
    idle(19);

    // dwell=0 acts as 1; start while busy ignored; stop+wrap aborts to min
    start_ramp(2, 10, 4, 0, 1'b1);
    wr(1'b1, 6);
    start_ramp(7, 20, 1, 1, 1'b0);
    check_val("t4_busy", busy, 1);
    check_val("t4_dir", dir, 1);
    pulse(1'b1, 1'b1, 1'b1, 2);
    check_val("t4_stop_busy", busy, 0);
    check_val("t4_stop_done", done, 0);
    check_val("t4_stop_dir", dir, 0);
    idle(3);
    wr(1'b0, 0);
    check_val("t4_idle_wrap_busy", busy, 0);

    // Restart after stop, then reset mid-DOWN
    start_ramp(5, 20, 5, 1, 1'b1);
    check_val("t5_busy", busy, 1);
    wr(1'b1, 10);
    wr(1'b1, 15);
    wr(1'b1, 20);
    hold_wraps(2);
    wr(1'b1, 15);
    check_val("t5_down_dir", dir, 0);
    push_exp(0);
    #1 rst_n = 1'b0;
    #1;
    check_val("t5_rst_speed", speed, 0);
    check_val("t5_rst_busy", busy, 0);
    check_val("t5_rst_dir", dir, 0);
    check_val("t5_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check_val("done_count_a", done_cnt, 3);

    // Degenerate bounds: done pulse only, no ramp
    start_ramp(8, 8, 1, 1, 1'b0);
    check_val("t6_done", done, 1);
    check_val("t6_busy", busy, 0);
    idle(1);
    check_val("t6_done_clr", done, 0);
    start_ramp(1, 5, 0, 1, 1'b0);
    check_val("t6_step0_done", done, 1);
    check_val("t6_step0_busy", busy, 0);
    idle(3);
    check_val("done_count_b", done_cnt, 5);
    check_val("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
